// File: rtl/div_16bit.sv
// div_16bit: sequential restoring shift-subtract divider, one quotient bit per clock.
// start/done handshake; quo/rem/dbz are registered and change only on the done edge.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands, truncation toward zero).
`timescale 1ns/1ps
module div_16bit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             done,
   output logic             busy,
   output logic             dbz
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] dvd_q;     // dividend magnitude, quotient bits shift in at the LSB
   logic [WIDTH-1:0] dsr_q;     // divisor magnitude
   logic [WIDTH-1:0] r_q;       // partial remainder
   logic             zero_q;    // divisor was zero at capture
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic             done_q;
   logic             busy_q;
   logic             dbz_q;
`ifdef DIV_SIGNED_EN
   logic             negq_q;    // operand signs differ
   logic             negr_q;    // dividend negative
`endif

   logic [WIDTH:0]   r_sh;
   logic             ge;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] dvd_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign quo  = quo_q;
   assign rem  = rem_q;
   assign done = done_q;
   assign busy = busy_q;
   assign dbz  = dbz_q;

   // Operand magnitudes at capture time (identity in the unsigned build).
   always_comb begin
`ifdef DIV_SIGNED_EN
      a_mag = ain[WIDTH-1] ? -ain : ain;
      b_mag = bin[WIDTH-1] ? -bin : bin;
`else
      a_mag = ain;
      b_mag = bin;
`endif
   end

   // One restoring step plus the result fix-up used on the final iteration.
   // The shifted remainder keeps WIDTH+1 bits so large divisors never overflow the compare.
   // With a zero divisor the remainder simply accumulates the dividend bits, so it ends equal to the dividend.
   always_comb begin
      r_sh  = {r_q, dvd_q[WIDTH-1]};
      ge    = (r_sh >= {1'b0, dsr_q});
      r_d   = ge ? WIDTH'(r_sh - {1'b0, dsr_q}) : r_sh[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], ge};
`ifdef DIV_SIGNED_EN
      quo_d = zero_q ? '1 : (negq_q ? -dvd_d : dvd_d);
      rem_d = negr_q ? -r_d : r_d;
`else
      quo_d = zero_q ? '1 : dvd_d;
      rem_d = r_d;
`endif
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         r_q     <= '0;
         zero_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  dvd_q   <= a_mag;
                  dsr_q   <= b_mag;
                  r_q     <= '0;
                  cnt_q   <= '0;
                  zero_q  <= (bin == '0);
                  busy_q  <= 1'b1;
                  state_q <= S_CALC;
`ifdef DIV_SIGNED_EN
                  negq_q  <= ain[WIDTH-1] ^ bin[WIDTH-1];
                  negr_q  <= ain[WIDTH-1];
`endif
               end
            end
            S_CALC: begin
               dvd_q <= dvd_d;
               r_q   <= r_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  quo_q   <= quo_d;
                  rem_q   <= rem_d;
                  dbz_q   <= zero_q;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_16bit.sv
// tb_div_16bit: self-checking bench for div_16bit against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_16bit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] ain;
   logic [15:0] bin;
   logic [15:0] quo;
   logic [15:0] rem;
   logic        done;
   logic        busy;
   logic        dbz;

   int unsigned total = 0;
   int unsigned bad   = 0;

   div_16bit #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .ain   (ain),
      .bin   (bin),
      .quo   (quo),
      .rem   (rem),
      .done  (done),
      .busy  (busy),
      .dbz   (dbz)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on the operand values.
   task automatic model(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic z);
`ifdef DIV_SIGNED_EN
      int ia;
      int ib;
      ia = int'($signed(a));
      ib = int'($signed(b));
      if (b == 16'd0) begin
         q = 16'hFFFF; r = a; z = 1'b1;
      end else begin
         q = 16'(ia / ib); r = 16'(ia % ib); z = 1'b0;
      end
`else
      if (b == 16'd0) begin
         q = 16'hFFFF; r = a; z = 1'b1;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
`endif
   endtask

   // One division with latency/handshake checks; optionally disturbs start/ain/bin mid-calculation.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit disturb);
      logic [15:0] eq;
      logic [15:0] er;
      logic        ez;
      int unsigned lat;
      bit          seen;
      model(a, b, eq, er, ez);
      @(negedge clk);
      ain = a; bin = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_at_accept", busy, 1);
      chk("done_at_accept", done, 0);
      seen = 0;
      lat  = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         if (disturb && k >= 3 && k <= 8) begin
            @(negedge clk);
            start = 1'b1; ain = 16'($urandom); bin = 16'($urandom);
         end else if (disturb && k == 9) begin
            @(negedge clk);
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin
            seen = 1;
            lat  = k;
         end else begin
            chk("busy_during_calc", busy, 1);
         end
      end
      chk("latency", lat, 16);
      chk("quo", quo, eq);
      chk("rem", rem, er);
      chk("dbz", dbz, ez);
      chk("busy_at_done", busy, 1);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("busy_released", busy, 0);
      chk("quo_held", quo, eq);
      chk("rem_held", rem, er);
   endtask

   initial begin
      bit saw_done;
      rst_n = 1'b0; start = 1'b0; ain = '0; bin = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_quo", quo, 0);
      chk("rst_rem", rem, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dbz", dbz, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed unsigned cases.
      do_op(16'd100, 16'd7, 0);
      chk("t1_quo_const", quo, 16'd14);
      chk("t1_rem_const", rem, 16'd2);
      do_op(16'hFFFF, 16'h0001, 0);
      do_op(16'd5, 16'hFFFF, 0);
      do_op(16'd1234, 16'd0, 0);
      chk("t3_quo_const", quo, 16'hFFFF);
      chk("t3_rem_const", rem, 16'd1234);
      chk("t3_dbz_const", dbz, 1);
      do_op(16'd9, 16'd3, 0);
      chk("t3b_dbz_cleared", dbz, 0);
      do_op(16'hFFFF, 16'h8001, 0);

      // Operand changes and start re-pulses mid-calculation are ignored.
      do_op(16'd60000, 16'd123, 1);
      chk("t4_quo_const", quo, 16'd487);
      chk("t4_rem_const", rem, 16'd99);

      // Asynchronous reset in the middle of a calculation.
      do_op(16'd1234, 16'd0, 0);
      @(negedge clk);
      ain = 16'd40000; bin = 16'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_quo", quo, 0);
      chk("arst_rem", rem, 0);
      chk("arst_done", done, 0);
      chk("arst_busy", busy, 0);
      chk("arst_dbz", dbz, 0);
      saw_done = 0;
      repeat (2) begin
         @(posedge clk); #1;
         saw_done |= done;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         saw_done |= done;
      end
      chk("no_done_after_abort", saw_done, 0);
      do_op(16'd50, 16'd5, 0);
      chk("t5_quo_const", quo, 16'd10);
      chk("t5_rem_const", rem, 16'd0);

`ifdef DIV_SIGNED_EN
      do_op(16'hFFF9, 16'd2, 0);
      chk("s_q1", quo, 16'hFFFD);
      chk("s_r1", rem, 16'hFFFF);
      do_op(16'd7, 16'hFFFE, 0);
      chk("s_q2", quo, 16'hFFFD);
      chk("s_r2", rem, 16'd1);
      do_op(16'h8000, 16'hFFFF, 0);
      chk("s_q3", quo, 16'h8000);
      chk("s_r3", rem, 16'd0);
      chk("s_z3", dbz, 0);
      do_op(16'h8000, 16'd0, 0);
`endif

      // Randomized operands, with small and zero divisors mixed in.
      for (int i = 0; i < 24; i++) begin
         logic [15:0] a;
         logic [15:0] b;
         a = 16'($urandom);
         case ($urandom_range(3, 0))
            0:       b = 16'd0;
            1:       b = 16'($urandom_range(15, 1));
            default: b = 16'($urandom);
         endcase
         do_op(a, b, (i % 5) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
